// File: rtl/dsp_term_if.sv
// Character-input stream and display-bus signals of the text terminal.
// The master side feeds characters and answers display accesses; the slave side is the terminal.
interface dsp_term_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [11:0] dsp_addr;
  logic        dsp_en;
  logic        dsp_wr;
  logic        dsp_wt;
  logic [15:0] dsp_wdata;
  logic [15:0] dsp_rdata;

  modport master (
    output in_valid, in_char, dsp_wt, dsp_rdata,
    input  in_ready, dsp_addr, dsp_en, dsp_wr, dsp_wdata
  );

  modport slave (
    input  in_valid, in_char, dsp_wt, dsp_rdata,
    output in_ready, dsp_addr, dsp_en, dsp_wr, dsp_wdata
  );
endinterface

// File: rtl/dsp_term.sv
// Text terminal: turns a character stream into cell writes on a display bus,
// handling cursor motion, form-feed clear and hardware scroll by read/write copy.
module dsp_term #(
  parameter int unsigned ROWS = 30,
  parameter int unsigned COLS = 80,
  parameter logic [7:0]  ATTR = 8'h07
) (
  input  logic       clk,
  input  logic       reset,
  dsp_term_if.slave  bus,
  output logic [4:0] cur_row,
  output logic [6:0] cur_col,
  output logic       busy
);

  localparam logic [4:0] RowLast = 5'(ROWS - 1);
  localparam logic [6:0] ColLast = 7'(COLS - 1);
  localparam logic [7:0] Blank   = 8'h20;

  typedef enum logic [2:0] {StIdle, StWrite, StScrRd, StScrWr, StClr} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [6:0]  cur_col_q, cur_col_d;
  logic [7:0]  char_q, char_d;
  logic [4:0]  ptr_row_q, ptr_row_d;
  logic [6:0]  ptr_col_q, ptr_col_d;
  logic [15:0] rdata_q, rdata_d;
  // Set when the blank fill is the tail of a scroll rather than a full clear.
  logic        scroll_q, scroll_d;
  logic        accept;
  logic        newline;

  assign accept       = bus.in_valid && (state_q == StIdle);
  assign bus.in_ready = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign cur_row      = cur_row_q;
  assign cur_col      = cur_col_q;

  always_comb begin
    state_d       = state_q;
    cur_row_d     = cur_row_q;
    cur_col_d     = cur_col_q;
    char_d        = char_q;
    ptr_row_d     = ptr_row_q;
    ptr_col_d     = ptr_col_q;
    rdata_d       = rdata_q;
    scroll_d      = scroll_q;
    newline       = 1'b0;
    bus.dsp_en    = 1'b0;
    bus.dsp_wr    = 1'b0;
    bus.dsp_addr  = {cur_row_q, cur_col_q};
    bus.dsp_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.in_char >= 8'h20 && bus.in_char <= 8'h7e) begin
            char_d  = bus.in_char;
            state_d = StWrite;
          end else begin
            case (bus.in_char)
              8'h0d: cur_col_d = '0;
              8'h0a: newline = 1'b1;
              8'h08: if (cur_col_q != '0) cur_col_d = cur_col_q - 7'd1;
              8'h0c: begin
                state_d   = StClr;
                ptr_row_d = '0;
                ptr_col_d = '0;
                scroll_d  = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

      StWrite: begin
        bus.dsp_en    = 1'b1;
        bus.dsp_wr    = 1'b1;
        bus.dsp_wdata = {ATTR, char_q};
        state_d       = StIdle;
        if (cur_col_q == ColLast) begin
          newline = 1'b1;
        end else begin
          cur_col_d = cur_col_q + 7'd1;
        end
      end

      // Address and strobes stay put until the display drops its wait.
      StScrRd: begin
        bus.dsp_en   = 1'b1;
        bus.dsp_addr = {ptr_row_q, ptr_col_q};
        if (!bus.dsp_wt) begin
          rdata_d = bus.dsp_rdata;
          state_d = StScrWr;
        end
      end

      StScrWr: begin
        bus.dsp_en    = 1'b1;
        bus.dsp_wr    = 1'b1;
        bus.dsp_addr  = {ptr_row_q - 5'd1, ptr_col_q};
        bus.dsp_wdata = rdata_q;
        state_d       = StScrRd;
        if (ptr_col_q == ColLast) begin
          ptr_col_d = '0;
          if (ptr_row_q == RowLast) begin
            state_d   = StClr;
            ptr_row_d = RowLast;
          end else begin
            ptr_row_d = ptr_row_q + 5'd1;
          end
        end else begin
          ptr_col_d = ptr_col_q + 7'd1;
        end
      end

      StClr: begin
        bus.dsp_en    = 1'b1;
        bus.dsp_wr    = 1'b1;
        bus.dsp_addr  = {ptr_row_q, ptr_col_q};
        bus.dsp_wdata = {ATTR, Blank};
        if (ptr_col_q == ColLast) begin
          ptr_col_d = '0;
          if (ptr_row_q == RowLast) begin
            state_d   = StIdle;
            cur_col_d = '0;
            cur_row_d = scroll_q ? RowLast : 5'd0;
            scroll_d  = 1'b0;
          end else begin
            ptr_row_d = ptr_row_q + 5'd1;
          end
        end else begin
          ptr_col_d = ptr_col_q + 7'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    // Row advance from LF or column wrap; on the bottom row the cursor is frozen until
    // the scroll finishes.
    if (newline) begin
      if (cur_row_q == RowLast) begin
        scroll_d  = 1'b1;
        ptr_col_d = '0;
        if (ROWS > 1) begin
          state_d   = StScrRd;
          ptr_row_d = 5'd1;
        end else begin
          state_d   = StClr;
          ptr_row_d = RowLast;
        end
      end else begin
        state_d   = StIdle;
        cur_row_d = cur_row_q + 5'd1;
        cur_col_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_row_q <= '0;
      cur_col_q <= '0;
      char_q    <= '0;
      ptr_row_q <= '0;
      ptr_col_q <= '0;
      rdata_q   <= '0;
      scroll_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      char_q    <= char_d;
      ptr_row_q <= ptr_row_d;
      ptr_col_q <= ptr_col_d;
      rdata_q   <= rdata_d;
      scroll_q  <= scroll_d;
    end
  end

endmodule

// File: tb/tb_dsp_term.sv
// Randomised bench for dsp_term: a behavioural screen/cursor model predicts cursor, bus traffic,
// busy time and screen contents; the bench also plays the display memory.
module tb_dsp_term;
  localparam int unsigned ROWS = 30;
  localparam int unsigned COLS = 80;
  localparam logic [7:0]  ATTR = 8'h07;
  localparam logic [15:0] BlankCell = {ATTR, 8'h20};

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  dsp_term_if bus_if ();

  dsp_term #(.ROWS(ROWS), .COLS(COLS), .ATTR(ATTR)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Display memory played by the bench.
  logic [15:0] vram    [0:4095];
  logic [15:0] ref_scr [0:4095];
  logic        mem_init;
  logic        rd_seen;
  logic [11:0] prev_rd_addr;
  logic [11:0] last_wr_addr;
  logic [15:0] last_wr_data;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rd_hold_viol = 0;
  int          en_idle_viol = 0;

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 40503) ^ 16'h5a5a);
  endfunction

  // Each read waits exactly one cycle before data is valid.
  assign bus_if.dsp_wt    = bus_if.dsp_en && !bus_if.dsp_wr && !rd_seen;
  assign bus_if.dsp_rdata = vram[bus_if.dsp_addr];

  always @(posedge clk) begin
    if (reset) rd_seen <= 1'b0;
    else if (bus_if.dsp_en && !bus_if.dsp_wr) rd_seen <= !rd_seen;
    else rd_seen <= 1'b0;
  end

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) vram[i] <= init_word(i);
    end else if (bus_if.dsp_en && bus_if.dsp_wr) begin
      vram[bus_if.dsp_addr] <= bus_if.dsp_wdata;
    end
    if (bus_if.dsp_en && bus_if.dsp_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus_if.dsp_addr;
      last_wr_data <= bus_if.dsp_wdata;
    end
    if (bus_if.dsp_en && !bus_if.dsp_wr) begin
      if (!rd_seen) rd_cnt <= rd_cnt + 1;
      else if (bus_if.dsp_addr != prev_rd_addr) rd_hold_viol <= rd_hold_viol + 1;
      prev_rd_addr <= bus_if.dsp_addr;
    end
    if (bus_if.dsp_en && !busy) en_idle_viol <= en_idle_viol + 1;
  end

  // Behavioural model: cursor plus a flat screen image.
  int m_row, m_col;

  function automatic bit printable(input logic [7:0] ch);
    return ch >= 8'h20 && ch <= 8'h7e;
  endfunction

  task automatic model_newline(inout int busy_c, inout int wr_c, inout int rd_c);
    if (m_row == ROWS - 1) begin
      for (int r = 1; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) ref_scr[(r - 1) * 128 + c] = ref_scr[r * 128 + c];
      for (int c = 0; c < COLS; c++) ref_scr[(ROWS - 1) * 128 + c] = BlankCell;
      busy_c += 3 * (ROWS - 1) * COLS + COLS;
      wr_c   += (ROWS - 1) * COLS + COLS;
      rd_c   += (ROWS - 1) * COLS;
    end else begin
      m_row++;
    end
    m_col = 0;
  endtask

  task automatic model_char(input logic [7:0] ch, output int busy_c, output int wr_c,
                            output int rd_c);
    busy_c = 0;
    wr_c   = 0;
    rd_c   = 0;
    if (printable(ch)) begin
      ref_scr[m_row * 128 + m_col] = {ATTR, ch};
      busy_c = 1;
      wr_c   = 1;
      m_col++;
      if (m_col == COLS) model_newline(busy_c, wr_c, rd_c);
    end else if (ch == 8'h0d) begin
      m_col = 0;
    end else if (ch == 8'h0a) begin
      model_newline(busy_c, wr_c, rd_c);
    end else if (ch == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (ch == 8'h0c) begin
      for (int i = 0; i < 4096; i++) if ((i % 128) < COLS && (i / 128) < ROWS) ref_scr[i] = BlankCell;
      m_row  = 0;
      m_col  = 0;
      busy_c = ROWS * COLS;
      wr_c   = ROWS * COLS;
    end
  endtask

  task automatic check_screen(input string tag);
    int diffs = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (vram[r * 128 + c] !== ref_scr[r * 128 + c]) diffs++;
    check(tag, diffs, 0);
  endtask

  // Send one character, optionally holding in_valid with junk while busy, then check outcome.
  task automatic send(input logic [7:0] ch, input bit hold_junk);
    int exp_busy, exp_wr, exp_rd, n, wr0, rd0;
    logic [11:0] exp_addr;
    exp_addr = {5'(m_row), 7'(m_col)};
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    model_char(ch, exp_busy, exp_wr, exp_rd);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_char  = ch;
    @(posedge clk);
    #1;
    if (hold_junk) bus_if.in_char = 8'(32 + $urandom_range(94));
    else bus_if.in_valid = 1'b0;
    n = 0;
    while (!bus_if.in_ready && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("busy_cycles", n, exp_busy);
    check("write_count", wr_cnt - wr0, exp_wr);
    check("read_count", rd_cnt - rd0, exp_rd);
    check("cur_row", cur_row, m_row);
    check("cur_col", cur_col, m_col);
    if (exp_busy == 1) begin
      check("write_addr", last_wr_addr, exp_addr);
      check("write_data", last_wr_data, {ATTR, ch});
    end
  endtask

  initial begin
    int scrolls, ffs, wr_at_reset;
    logic [7:0] ch;
    bus_if.in_valid = 1'b0;
    bus_if.in_char  = 8'h00;
    reset    = 1'b1;
    mem_init = 1'b1;
    for (int i = 0; i < 4096; i++) ref_scr[i] = init_word(i);
    m_row = 0;
    m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    reset    = 1'b0;
    check("rst_in_ready", bus_if.in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_dsp_en", bus_if.dsp_en, 1'b0);
    check("rst_dsp_wr", bus_if.dsp_wr, 1'b0);
    check("rst_cur_row", cur_row, 0);
    check("rst_cur_col", cur_col, 0);

    send(8'h41, 1'b0);
    send(8'h0c, 1'b1);
    check_screen("ff_screen");

    for (int i = 0; i < COLS; i++) send(8'(32 + $urandom_range(94)), 1'($urandom_range(1)));
    check_screen("line_screen");

    send(8'h0d, 1'b0);
    send(8'h08, 1'b0);
    for (int i = 0; i < 7; i++) send(8'(32 + $urandom_range(94)), 1'b0);
    send(8'h0d, 1'b0);
    send(8'h01, 1'b0);

    while (m_row != ROWS - 1) send(8'h0a, 1'($urandom_range(1)));
    for (int i = 0; i < 5; i++) send(8'(32 + $urandom_range(94)), 1'b0);
    send(8'h0a, 1'b1);
    check_screen("scroll_screen");

    scrolls = 0;
    ffs     = 0;
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 65) ch = 8'(32 + $urandom_range(94));
      else if (r < 72) ch = 8'h0d;
      else if (r < 80) ch = 8'h0a;
      else if (r < 86) ch = 8'h08;
      else if (r < 88) ch = 8'h0c;
      else ch = 8'($urandom_range(255));
      if (m_row == ROWS - 1 && (ch == 8'h0a || (printable(ch) && m_col == COLS - 1))) begin
        if (scrolls >= 3) ch = 8'h01;
        else scrolls++;
      end
      if (ch == 8'h0c) begin
        if (ffs >= 2) ch = 8'h01;
        else ffs++;
      end
      send(ch, 1'($urandom_range(1)));
    end
    check_screen("random_screen");

    // Abort a scroll with reset.
    while (m_row != ROWS - 1) send(8'h0a, 1'b0);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_char  = 8'h0a;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat ($urandom_range(4000, 20)) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_dsp_en", bus_if.dsp_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", bus_if.in_ready, 1'b1);
    check("abort_cur_row", cur_row, 0);
    check("abort_cur_col", cur_col, 0);
    @(negedge clk);
    wr_at_reset = wr_cnt;
    repeat (3) @(negedge clk);
    check("abort_quiet", wr_cnt - wr_at_reset, 0);
    // Screen after an aborted scroll is unspecified; adopt it as the new reference.
    for (int i = 0; i < 4096; i++) ref_scr[i] = vram[i];
    m_row = 0;
    m_col = 0;
    send(8'h5a, 1'b0);
    check_screen("abort_screen");

    check("rd_hold_viol", rd_hold_viol, 0);
    check("en_idle_viol", en_idle_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
